deit_stream_feeder: RTL
=======================

// Module: deit_stream_feeder
// PURPOSE
// - Synthesizable stimulus engine for on-FPGA bring-up of deit_core; replaces a bench-only reactive feeder.
// - Issues ap_start and watches ap_done with a watchdog. Answers the core's weight-load/input-stream strobes with generated vectors.
// - Counts beats and flags mismatches against cfg_compute_cycles. Sits between the AXI-lite CSR block and deit_core.
// PARAMETERS
// - ROWS        12  activation lanes (matches ARRAY_ROW)
// - COLS        12  weight lanes (matches ARRAY_COL)
// - DATA_WIDTH  8   bits per lane
// - TMO_W       16  watchdog counter width
// PORTS
// - clk                   in   1              system clock
// - rst_n                 in   1              synchronous reset, active-low
// - run                   in   1              start pulse from CSR
// - cfg_mode              in   2              0=const 1=ramp 2=lfsr 3=zero
// - cfg_const             in   DATA_WIDTH     lane value in const mode
// - cfg_compute_cycles    in   32             expected activation beats
// - cfg_timeout           in   TMO_W          watchdog limit in cycles, 0=disabled
// - core_ap_start         out  1              start pulse to core
// - core_ap_done          in   1              core completion
// - core_weight_load_en   in   1              core requests a weight vector
// - core_input_stream_en  in   1              core requests an activation vector
// - in_weight_vec         out  COLS*DATA_WIDTH   weight vector to core
// - in_act_vec            out  ROWS*DATA_WIDTH   activation vector to core
// - busy                  out  1              high from START through RUN
// - done                  out  1              1-cycle pulse on normal completion
// - timeout_err           out  1              sticky until next accepted run
// - beat_mismatch         out  1              sticky; act_beats != cfg_compute_cycles at done
// - wgt_beats             out  16             weight beats served, saturating
// - act_beats             out  32             activation beats served, saturating
// - act_checksum          out  32             see CONFIGURATION
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): FSM=IDLE; all outputs, counters, LFSR seed (0xACE1) cleared or reloaded. Applies mid-run too: core_ap_start stays 0.
// - FSM states and transitions:
//   - IDLE: run=1 clears the status flags and counters. It goes to DONE_S if cfg_compute_cycles==0, otherwise to START.
//   - START: core_ap_start=1 for exactly one cycle, then RUN.
//   - RUN: watchdog counts up. core_ap_done -> DONE_S. If watchdog==cfg_timeout (nonzero) -> ERR.
//   - DONE_S: done=1 for one cycle, beat_mismatch evaluated, then IDLE.
//   - ERR: timeout_err=1, then IDLE.
// - run is ignored outside IDLE. core_ap_done and timeout in the same cycle: done wins.
// - Strobes are honoured only in RUN; outside RUN both vectors are 0.
// - All vector outputs are registered, so data appears the cycle after a strobe is sampled high.
// - in_act_vec goes to 0 on the cycle after core_input_stream_en is sampled low.
// - in_weight_vec holds its last value when core_weight_load_en is low.
// - Per-beat generation. n = beat index of that stream (wgt_beats or act_beats before increment), k = lane:
//   - const: every lane = cfg_const.
//   - ramp: lane k = (n+k) mod 2^DATA_WIDTH.
//   - lfsr: 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11+1, one shared register. It steps once for each served beat of either stream; lane k = lfsr[DATA_WIDTH-1:0] ^ k.
//   - zero: every lane = 0.
// - Both strobes high in one cycle: both vectors are served. In lfsr mode the weight vector uses the current state and the activation vector uses the next state; the LFSR advances twice.
// - Counters saturate at all-ones and never wrap. cfg_timeout=0 disables the watchdog.
// CONFIGURATION
// - DEIT_FEEDER_CHECKSUM_EN defined: act_checksum is the 32-bit wrap-around sum of every activation lane served in the run (unsigned). It is cleared on an accepted run.
// - Macro undefined: act_checksum is tied to 0 and no adder logic is built.
// TESTING
// - const, cfg_const=1, 16 cycles, core mock streams 16 beats then asserts done:
//   - every act lane = 0x01; act_beats=16; done pulses once; beat_mismatch=0; timeout_err=0.
// - ramp, 4 act beats:
//   - beat0 lanes 0..11 = 0..11; beat3 lane11 = 14; in_act_vec=0 on the cycle after the strobe falls.
// - cfg_timeout=100, core never asserts done:
//   - timeout_err=1 at cycle 100 of RUN; busy falls; done stays 0; a second run clears timeout_err.
// - cfg_compute_cycles=0 with run:
//   - core_ap_start never asserted; done pulses two cycles after run; beat_mismatch=0.
// - Mock streams 15 beats with cfg_compute_cycles=16: beat_mismatch=1.
//   - With DEIT_FEEDER_CHECKSUM_EN and const=2, 16 beats x 12 lanes: act_checksum=384.
// - rst_n low for 1 cycle mid-RUN:
//   - all outputs 0 next cycle; FSM=IDLE; a subsequent run starts cleanly with the LFSR at 0xACE1.

Source files
------------

// File: rtl/deit_stream_feeder.sv
// Stimulus engine for deit_core bring-up: start/watchdog FSM plus vector generators.
// Optional DEIT_FEEDER_CHECKSUM_EN builds a running sum of served activation lanes.
module deit_stream_feeder #(
  parameter int ROWS       = 12,
  parameter int COLS       = 12,
  parameter int DATA_WIDTH = 8,
  parameter int TMO_W      = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       run,
  input  logic [1:0]                 cfg_mode,
  input  logic [DATA_WIDTH-1:0]      cfg_const,
  input  logic [31:0]                cfg_compute_cycles,
  input  logic [TMO_W-1:0]           cfg_timeout,
  output logic                       core_ap_start,
  input  logic                       core_ap_done,
  input  logic                       core_weight_load_en,
  input  logic                       core_input_stream_en,
  output logic [COLS*DATA_WIDTH-1:0] in_weight_vec,
  output logic [ROWS*DATA_WIDTH-1:0] in_act_vec,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout_err,
  output logic                       beat_mismatch,
  output logic [15:0]                wgt_beats,
  output logic [31:0]                act_beats,
  output logic [31:0]                act_checksum
);

  typedef enum logic [2:0] {
    IDLE, START, RUN, DONE_S, ERR
  } state_t;

  state_t state, state_nx;

  logic [TMO_W-1:0] wd;
  logic [15:0] lfsr, lfsr_a, lfsr_nx;
  logic        accept, w_srv, a_srv;
  logic [COLS*DATA_WIDTH-1:0] w_gen;
  logic [ROWS*DATA_WIDTH-1:0] a_gen;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    lfsr_step = {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] lane_val(
    input logic [1:0]            mode,
    input logic [DATA_WIDTH-1:0] cval,
    input logic [DATA_WIDTH-1:0] n,
    input logic [15:0]           l,
    input logic [DATA_WIDTH-1:0] k
  );
    unique case (mode)
      2'd0:    lane_val = cval;
      2'd1:    lane_val = n + k;
      2'd2:    lane_val = l[DATA_WIDTH-1:0] ^ k;
      default: lane_val = '0;
    endcase
  endfunction

  assign accept        = (state == IDLE) && run;
  assign w_srv         = (state == RUN) && core_weight_load_en;
  assign a_srv         = (state == RUN) && core_input_stream_en;
  assign core_ap_start = (state == START);
  assign busy          = (state == START) || (state == RUN);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (run)
          state_nx = (cfg_compute_cycles == 32'd0) ? DONE_S : START;
      START:
        state_nx = RUN;
      RUN:
        if (core_ap_done)
          state_nx = DONE_S;
        else if (cfg_timeout != '0 && wd == cfg_timeout)
          state_nx = ERR;
      DONE_S, ERR:
        state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  // Weight lanes use the current LFSR state; a concurrent act beat sees the stepped one.
  always_comb begin
    lfsr_a  = w_srv ? lfsr_step(lfsr) : lfsr;
    lfsr_nx = a_srv ? lfsr_step(lfsr_a) : lfsr_a;
    w_gen   = '0;
    a_gen   = '0;
    for (int k = 0; k < COLS; k++)
      w_gen[k*DATA_WIDTH +: DATA_WIDTH] = lane_val(
        cfg_mode, cfg_const, wgt_beats[DATA_WIDTH-1:0],
        lfsr, DATA_WIDTH'(k));
    for (int k = 0; k < ROWS; k++)
      a_gen[k*DATA_WIDTH +: DATA_WIDTH] = lane_val(
        cfg_mode, cfg_const, act_beats[DATA_WIDTH-1:0],
        lfsr_a, DATA_WIDTH'(k));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      lfsr          <= 16'hACE1;
      wd            <= '0;
      done          <= 1'b0;
      timeout_err   <= 1'b0;
      beat_mismatch <= 1'b0;
      wgt_beats     <= '0;
      act_beats     <= '0;
      in_weight_vec <= '0;
      in_act_vec    <= '0;
    end else begin
      state <= state_nx;
      lfsr  <= lfsr_nx;
      done  <= (state == DONE_S);
      if (state == START)
        wd <= TMO_W'(1);
      else if (state == RUN && wd != '1)
        wd <= wd + 1'b1;
      if (accept) begin
        timeout_err   <= 1'b0;
        beat_mismatch <= 1'b0;
        wgt_beats     <= '0;
        act_beats     <= '0;
      end else begin
        if (state == ERR)
          timeout_err <= 1'b1;
        if (state == DONE_S)
          beat_mismatch <= (act_beats != cfg_compute_cycles);
        if (w_srv && wgt_beats != '1)
          wgt_beats <= wgt_beats + 1'b1;
        if (a_srv && act_beats != '1)
          act_beats <= act_beats + 1'b1;
      end
      if (w_srv)
        in_weight_vec <= w_gen;
      else if (state != RUN)
        in_weight_vec <= '0;
      in_act_vec <= a_srv ? a_gen : '0;
    end
  end

`ifdef DEIT_FEEDER_CHECKSUM_EN
  logic [31:0] a_sum;
  logic [31:0] csum;

  always_comb begin
    a_sum = '0;
    for (int k = 0; k < ROWS; k++)
      a_sum = a_sum + 32'(a_gen[k*DATA_WIDTH +: DATA_WIDTH]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      csum <= '0;
    else if (accept)
      csum <= '0;
    else if (a_srv)
      csum <= csum + a_sum;
  end

  assign act_checksum = csum;
`else
  assign act_checksum = '0;
`endif

endmodule
